// File: rtl/result_fifo.sv
// result_fifo: first-word-fall-through circular buffer for 21-bit wrapper results.
// Handshakes words out to the consumer over valid/ready, tracks occupancy, and
// latches a sticky overflow flag when a write has to be dropped at full.
module result_fifo #(
  parameter int WIDTH  = 21,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_req,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  // Flags come from the registered count only, so no input reaches them combinationally.
  always_comb begin
    full      = (r_count == LP_DEPTH);
    out_valid = (r_count != '0);
    out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    count     = r_count;
    overflow  = r_overflow;
  end

  // Handshake decode; a write at full only fits if the head leaves this cycle,
  // and a flush swallows the write of its own cycle without flagging overflow.
  always_comb begin
    w_pop  = out_valid & out_ready;
    w_push = wr_req & (~full | w_pop) & ~clr;
    w_drop = wr_req & full & ~w_pop & ~clr;
  end

  // Storage write port; entries are only ever overwritten by accepted pushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow, cleared only by flush or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

endmodule
